// File: rtl/sha256_block_feeder_if.sv
// SHA-256 feeder bus bundle: word-memory read port plus the start/done
// handshake towards the compression processor.
// master = feeder side, slave = memory/processor side.
interface sha256_block_feeder_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_read_data;
   logic              proc_start;
   logic [511:0]      proc_w;
   logic [255:0]      proc_h;
   logic              proc_done;
   logic [255:0]      proc_hash;

   modport master (
      output mem_addr, proc_start, proc_w, proc_h,
      input  mem_read_data, proc_done, proc_hash
   );

   modport slave (
      input  mem_addr, proc_start, proc_w, proc_h,
      output mem_read_data, proc_done, proc_hash
   );
endinterface

// File: rtl/sha256_block_feeder.sv
// SHA-256 block feeder: reads a word-aligned message, applies SHA-256
// padding, hands each 512-bit block plus chaining value to the compression
// processor and returns the final digest.
// Optional build macro BYTE_SWAP_EN: byte-reverse every memory word before
// buffering (little-endian images); pad and length words are never swapped.
module sha256_block_feeder #(
   parameter int MAX_WORDS = 20,
   parameter int ADDR_W    = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     msg_addr,
   input  logic [7:0]            msg_words,
   sha256_block_feeder_if.master bus,
   output logic [255:0]          digest,
   output logic                  busy,
   output logic                  done
);

   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Reverse the byte order of a 32-bit word.
   function automatic logic [31:0] byte_rev(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;

   logic [ADDR_W-1:0] addr_r;
   logic [7:0]        words_r;
   logic [7:0]        blk_r;
   logic [4:0]        cnt_r;
   logic [511:0]      buf_r;
   logic [255:0]      chain_r;

   logic [ADDR_W-1:0] mem_addr_r;
   logic              proc_start_r;
   logic [511:0]      proc_w_r;
   logic [255:0]      proc_h_r;
   logic [255:0]      digest_r;
   logic              busy_r;
   logic              done_r;

   logic              accept_s;
   logic              load_s;
   logic              issue_s;
   logic              chain_upd_s;
   logic              next_blk_s;
   logic              finish_s;

   logic [3:0]        wr_idx_s;
   logic [3:0]        slot_s;
   logic [11:0]       g_s;
   logic [11:0]       words_ext_s;
   logic [7:0]        last_blk_s;
   logic              is_last_blk_s;
   logic [31:0]       mem_word_s;
   logic [31:0]       pad_word_s;

   assign bus.mem_addr   = mem_addr_r;
   assign bus.proc_start = proc_start_r;
   assign bus.proc_w     = proc_w_r;
   assign bus.proc_h     = proc_h_r;
   assign digest         = digest_r;
   assign busy           = busy_r;
   assign done           = done_r;

`ifdef BYTE_SWAP_EN
   assign mem_word_s = byte_rev(bus.mem_read_data);
`else
   assign mem_word_s = bus.mem_read_data;
`endif

   // Index of the block that carries the length field: nblk-1.
   assign last_blk_s    = 8'(({1'b0, words_r} + 9'd2) >> 4);
   assign is_last_blk_s = (blk_r == last_blk_s);

   // In LOAD cycle k the word written is k-1; k=16 wraps to slot 15.
   assign wr_idx_s    = cnt_r[3:0] - 4'd1;
   assign slot_s      = 4'd15 - wr_idx_s;
   assign g_s         = {blk_r, 4'b0000} + {8'd0, wr_idx_s};
   assign words_ext_s = {4'd0, words_r};

   // Select message data, the 0x80 marker, the length word or zero.
   always_comb begin
      pad_word_s = 32'd0;
      if (g_s < words_ext_s) begin
         pad_word_s = mem_word_s;
      end else if (g_s == words_ext_s) begin
         pad_word_s = 32'h8000_0000;
      end else if (is_last_blk_s && (wr_idx_s == 4'd15)) begin
         pad_word_s = {19'd0, words_r, 5'd0};
      end else begin
         pad_word_s = 32'd0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state and per-state control strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      load_s      = 1'b0;
      issue_s     = 1'b0;
      chain_upd_s = 1'b0;
      next_blk_s  = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && (msg_words <= 8'(MAX_WORDS))) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            load_s = 1'b1;
            if (cnt_r == 5'd16) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_ISSUE: begin
            issue_s     = 1'b1;
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.proc_done) begin
               chain_upd_s = 1'b1;
               if (blk_r < last_blk_s) begin
                  next_blk_s  = 1'b1;
                  state_nxt_s = ST_LOAD;
               end else begin
                  state_nxt_s = ST_FINISH;
               end
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_FINISH: begin
            finish_s    = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Datapath: request latch, block buffer, chaining value and outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_r       <= '0;
         words_r      <= 8'd0;
         blk_r        <= 8'd0;
         cnt_r        <= 5'd0;
         buf_r        <= 512'd0;
         chain_r      <= 256'd0;
         mem_addr_r   <= '0;
         proc_start_r <= 1'b0;
         proc_w_r     <= 512'd0;
         proc_h_r     <= 256'd0;
         digest_r     <= 256'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         proc_start_r <= issue_s;
         done_r       <= finish_s;
         busy_r       <= (state_nxt_s != ST_IDLE);

         if (accept_s) begin
            addr_r     <= msg_addr;
            words_r    <= msg_words;
            chain_r    <= SHA256_IV;
            blk_r      <= 8'd0;
            cnt_r      <= 5'd0;
            mem_addr_r <= msg_addr;
            digest_r   <= 256'd0;
         end

         if (load_s) begin
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r != 5'd0) begin
               buf_r[{slot_s, 5'd0} +: 32] <= pad_word_s;
            end
            // Present the address for the next cycle; data lags by one.
            if (cnt_r < 5'd15) begin
               mem_addr_r <= addr_r + ADDR_W'({blk_r, 4'b0000}) + ADDR_W'(cnt_r + 5'd1);
            end
         end

         if (issue_s) begin
            proc_w_r <= buf_r;
            proc_h_r <= chain_r;
         end

         if (chain_upd_s) begin
            chain_r <= bus.proc_hash;
         end

         if (next_blk_s) begin
            blk_r      <= blk_r + 8'd1;
            cnt_r      <= 5'd0;
            mem_addr_r <= addr_r + ADDR_W'({blk_r + 8'd1, 4'b0000});
         end

         if (finish_s) begin
            digest_r <= chain_r;
         end
      end
   end

endmodule

// File: doc/sha256_block_feeder.md
Name: sha256_block_feeder

Overview:
- Feeder (initiator) side of the SHA-256 block-processor interface.
- Reads a word-aligned message from memory and applies SHA-256 padding.
- Presents each 512-bit block, together with the current chaining value, to the compression processor through a start/done handshake.
- Chains the returned hash into the next block and outputs the final 256-bit digest.

Parameters:
- MAX_WORDS, 20, maximum message length in 32-bit words; wider requests are rejected.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  begin hashing; sampled in IDLE only.
- msg_addr  in  ADDR_W  base word address of the message.
- msg_words  in  8  message length in words, valid range 0..MAX_WORDS.
- mem_addr  out  ADDR_W  memory read address.
- mem_read_data  in  32  memory data; valid the cycle after mem_addr is presented.
- proc_start  out  1  one-cycle pulse; proc_w and proc_h are valid while it is high and held until proc_done.
- proc_w  out  512  block words; w0 at [511:480], w15 at [31:0].
- proc_h  out  256  chaining input; h0 at [255:224].
- proc_done  in  1  processor completion pulse.
- proc_hash  in  256  updated chaining value (feed-forward already added); valid with proc_done.
- digest  out  256  final hash; h0 at [255:224].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when digest is valid.

Behaviour:
- Reset (rstn=0 at a clk edge) returns to IDLE from any state. Outputs clear: proc_start=0, proc_w=0, proc_h=0, digest=0, busy=0, done=0, mem_addr=0.
- An in-flight processor run is abandoned; a later proc_done is ignored.
- Block count: nblk = (msg_words+2)/16 + 1, integer division. Examples: 0..13 words give 1 block; 14..20 words give 2 blocks.
- Padded stream, global word index g = 16*blk + j:
  - g < msg_words: mem[msg_addr+g].
  - g == msg_words: 32'h80000000.
  - Last two words of the final block: 32'h00000000, then msg_words*32.
  - All other words: 0.
- State IDLE: on start with msg_words <= MAX_WORDS, latch msg_addr and msg_words, set chain to the SHA-256 IVs (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19), blk=0, go to LOAD.
- start with msg_words > MAX_WORDS is ignored; the block stays in IDLE.
- State LOAD: a counter runs 0..16, exactly 17 cycles per block.
  - Cycle k<16 drives mem_addr = msg_addr + 16*blk + k.
  - Cycle k>=1 writes word k-1 from mem_read_data or from the synthesized pad.
  - Memory addresses beyond the message are still driven but their data is discarded.
  - After cycle 16, go to ISSUE.
- State ISSUE: drive proc_w from the buffer and proc_h from the chain, pulse proc_start for one cycle, go to WAIT.
- State WAIT: hold proc_w and proc_h stable. On proc_done, chain <= proc_hash.
  - If blk < nblk-1: blk++ and go to LOAD.
  - Otherwise go to FINISH.
  - There is no timeout.
- State FINISH: digest <= chain, pulse done for one cycle, go to IDLE. digest holds until the next accepted start or reset.
- start while busy is ignored. proc_done outside WAIT is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- The length field is 64-bit big-endian; its upper word is always 0 for this range.

Optional Feature:
- BYTE_SWAP_EN defined: each word read from memory is byte-reversed before buffering ({b0,b1,b2,b3} -> {b3,b2,b1,b0}), for little-endian memory images.
- Pad and length words are never swapped.
- Not defined: memory words are used as-is.

Test Plan:
- msg_words=1, mem[0x10]=0x61626364, msg_addr=0x10 -> one proc_start 18 cycles after start.
  - proc_w = 61626364, 80000000, then 13 zero words, then 00000020.
  - proc_h = IVs.
  - Stub proc_hash = 88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589 -> digest equals it, done pulses once.
- msg_words=14, incrementing data 1..14 -> two blocks.
  - Block 0: words 1..14, then 80000000, then 0.
  - Block 1: 14 zero words, then 0, then 0x1C0.
  - Block 1 proc_h equals the stub block-0 proc_hash.
- msg_words=0 -> one block: 80000000, 14 zero words, then length 0. No memory data is used.
- msg_words=21 with MAX_WORDS=20 -> start ignored; busy stays 0, no mem activity.
- rstn low during WAIT, then proc_done after release -> all outputs return to reset values, no done pulse; the next start runs normally.
- BYTE_SWAP_EN, mem word 0x64636261 -> proc_w w0 = 0x61626364; pad word w1 = 0x80000000 unchanged.
